// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EXE bus, waits for load responses, aligns/extends load data.
// Optional MEM_STAGE_STALL_CNT_EN adds ms_stall_cnt, a free-running count of load-pending cycles.
module mem_stage #(
    parameter int ES_TO_MS_WD = 125,
    parameter int MS_TO_WS_WD = 117
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ws_allowin,
    output logic                   ms_allowin,
    input  logic                   es_to_ms_valid,
    input  logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
    input  logic                   ex_from_ws,
    input  logic                   data_sram_data_ok,
    input  logic [31:0]            data_sram_rdata,
    output logic                   ms_to_ws_valid,
    output logic [MS_TO_WS_WD-1:0] ms_to_ws_bus,
    output logic                   ex_from_ms,
    output logic [31:0]            ms_forward,
    output logic                   ms_fwd_ok,
`ifdef MEM_STAGE_STALL_CNT_EN
    output logic                   ms_load_pending,
    output logic [31:0]            ms_stall_cnt
`else
    output logic                   ms_load_pending
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t                 state;
    logic                   ms_valid;
    logic                   drop;
    logic [ES_TO_MS_WD-1:0] es_bus_r;
    logic [31:0]            rbuf;

    logic        eret, bd, mtc0_we, ex, res_from_cp0, lwl, lwr;
    logic        ld_w, ld_h, ld_b, ld_sign, gr_we;
    logic [4:0]  cp0_addr, excode, dest;
    logic [31:0] rt_value, alu_result, pc;
    logic [1:0]  offset;

    assign eret         = es_bus_r[124];
    assign bd           = es_bus_r[123];
    assign mtc0_we      = es_bus_r[122];
    assign cp0_addr     = es_bus_r[121:117];
    assign ex           = es_bus_r[116];
    assign excode       = es_bus_r[115:111];
    assign res_from_cp0 = es_bus_r[110];
    assign lwl          = es_bus_r[109];
    assign lwr          = es_bus_r[108];
    assign rt_value     = es_bus_r[107:76];
    assign ld_w         = es_bus_r[75];
    assign ld_h         = es_bus_r[74];
    assign ld_b         = es_bus_r[73];
    assign ld_sign      = es_bus_r[72];
    assign offset       = es_bus_r[71:70];
    assign gr_we        = es_bus_r[69];
    assign dest         = es_bus_r[68:64];
    assign alu_result   = es_bus_r[63:32];
    assign pc           = es_bus_r[31:0];

    logic need_data, es_need_data, data_hit, ms_ready_go;

    assign need_data    = (ld_w | ld_h | ld_b | lwl | lwr) & ~ex;
    assign es_need_data = (es_to_ms_bus[75] | es_to_ms_bus[74] | es_to_ms_bus[73] |
                           es_to_ms_bus[109] | es_to_ms_bus[108]) & ~es_to_ms_bus[116];
    // A response only belongs to the load in WAIT when no stale response is still owed.
    assign data_hit     = (state == WAIT) & data_sram_data_ok & ~drop;
    assign ms_ready_go  = ~need_data | (state == HOLD) | data_hit;

    assign ms_allowin      = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid  = ms_valid & ms_ready_go;
    assign ex_from_ms      = ms_valid & (ex | eret);
    assign ms_fwd_ok       = ms_valid & gr_we & ms_ready_go;
    assign ms_load_pending = ms_valid & need_data & ~ms_ready_go;

    logic [31:0] d, half_ext, byte_ext, load_data, result;
    logic [15:0] half;
    logic [7:0]  byte_v;

    always_comb begin
        d         = (state == HOLD) ? rbuf : data_sram_rdata;
        half      = offset[1] ? d[31:16] : d[15:0];
        half_ext  = {{16{ld_sign & half[15]}}, half};
        byte_v    = d[8*offset +: 8];
        byte_ext  = {{24{ld_sign & byte_v[7]}}, byte_v};
        load_data = d;
        if (ld_h) begin
            load_data = half_ext;
        end else if (ld_b) begin
            load_data = byte_ext;
        end else if (lwl) begin
            case (offset)
                2'd0:    load_data = {d[7:0],  rt_value[23:0]};
                2'd1:    load_data = {d[15:0], rt_value[15:0]};
                2'd2:    load_data = {d[23:0], rt_value[7:0]};
                default: load_data = d;
            endcase
        end else if (lwr) begin
            case (offset)
                2'd0:    load_data = d;
                2'd1:    load_data = {rt_value[31:24], d[31:8]};
                2'd2:    load_data = {rt_value[31:16], d[31:16]};
                default: load_data = {rt_value[31:8],  d[31:24]};
            endcase
        end
        result = need_data ? load_data : alu_result;
    end

    assign ms_forward   = result;
    assign ms_to_ws_bus = {eret, bd, mtc0_we, cp0_addr, ex, excode, res_from_cp0,
                           alu_result, gr_we, dest, result, pc};

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
            state    <= IDLE;
            drop     <= 1'b0;
            es_bus_r <= '0;
            rbuf     <= '0;
        end else begin
            if (data_sram_data_ok && drop)
                drop <= 1'b0;
            if (data_hit)
                rbuf <= data_sram_rdata;
            if (ex_from_ws) begin
                ms_valid <= 1'b0;
                state    <= IDLE;
                // The flushed load's response is still in flight; swallow it later.
                if (state == WAIT && !data_hit)
                    drop <= 1'b1;
            end else if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
                if (es_to_ms_valid) begin
                    es_bus_r <= es_to_ms_bus;
                    state    <= es_need_data ? WAIT : IDLE;
                end else begin
                    state <= IDLE;
                end
            end else if (data_hit) begin
                state <= HOLD;
            end
        end
    end

`ifdef MEM_STAGE_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            ms_stall_cnt <= '0;
        else if (ms_load_pending)
            ms_stall_cnt <= ms_stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: alignment vector table, hand-written stall/flush/exception
// sequences, then randomized traffic against a transaction-level reference model.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [124:0] es_to_ms_bus;
    logic         ex_from_ws;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         ms_to_ws_valid;
    logic [116:0] ms_to_ws_bus;
    logic         ex_from_ms;
    logic [31:0]  ms_forward;
    logic         ms_fwd_ok;
    logic         ms_load_pending;
`ifdef MEM_STAGE_STALL_CNT_EN
    logic [31:0]  ms_stall_cnt;
`endif

    mem_stage dut (
        .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .ex_from_ws(ex_from_ws), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .ms_to_ws_valid(ms_to_ws_valid),
        .ms_to_ws_bus(ms_to_ws_bus), .ex_from_ms(ex_from_ms), .ms_forward(ms_forward),
`ifdef MEM_STAGE_STALL_CNT_EN
        .ms_stall_cnt(ms_stall_cnt),
`endif
        .ms_fwd_ok(ms_fwd_ok), .ms_load_pending(ms_load_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic eret, bd, mtc0_we, ex, res_from_cp0, lwl, lwr, ld_w, ld_h, ld_b, ld_sign, gr_we;
        logic [4:0]  cp0_addr, excode, dest;
        logic [31:0] rt, alu, pc;
        logic [1:0]  off;
    } instr_t;

    // kind: 0 non-load, 1 LW, 2 LH, 3 LB, 4 LWL, 5 LWR, 6 excepting load
    typedef struct {
        int          kind;
        logic        sign;
        logic [1:0]  off;
        logic [31:0] rt, rdata, alu, exp;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic instr_t mk(input int kind, input logic sign, input logic [1:0] off,
                                  input logic [31:0] rt, input logic [31:0] alu);
        instr_t i;
        i = '{default: '0};
        i.ld_w = (kind == 1) || (kind == 6);
        i.ld_h = (kind == 2);
        i.ld_b = (kind == 3);
        i.lwl  = (kind == 4);
        i.lwr  = (kind == 5);
        i.ex   = (kind == 6);
        i.ld_sign = sign; i.off = off; i.rt = rt; i.alu = alu;
        i.gr_we = 1'b1; i.dest = 5'd5; i.pc = 32'hBFC0_0100;
        return i;
    endfunction

    function automatic logic [124:0] pack_es(input instr_t i);
        return {i.eret, i.bd, i.mtc0_we, i.cp0_addr, i.ex, i.excode, i.res_from_cp0, i.lwl, i.lwr,
                i.rt, i.ld_w, i.ld_h, i.ld_b, i.ld_sign, i.off, i.gr_we, i.dest, i.alu, i.pc};
    endfunction

    function automatic logic is_wait_load(input instr_t i);
        return (i.ld_w | i.ld_h | i.ld_b | i.lwl | i.lwr) & ~i.ex;
    endfunction

    // Reference alignment from shift/mask arithmetic.
    function automatic logic [31:0] ref_load(input instr_t i, input logic [31:0] d);
        logic [31:0] v;
        logic [63:0] m;
        int sh;
        sh = 8 * int'(i.off);
        if (i.ld_h) begin
            v = (d >> (16 * int'(i.off[1]))) & 32'hFFFF;
            if (i.ld_sign && v[15]) v = v | 32'hFFFF_0000;
        end else if (i.ld_b) begin
            v = (d >> sh) & 32'hFF;
            if (i.ld_sign && v[7]) v = v | 32'hFFFF_FF00;
        end else if (i.lwl) begin
            m = 64'hFFFF_FFFF >> (sh + 8);
            v = (d << (24 - sh)) | (i.rt & m[31:0]);
        end else if (i.lwr) begin
            m = 64'hFFFF_FFFF >> sh;
            v = (d >> sh) | (i.rt & ~m[31:0]);
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic logic [116:0] exp_bus(input instr_t i, input logic [31:0] d);
        logic [31:0] r;
        r = is_wait_load(i) ? ref_load(i, d) : i.alu;
        return {i.eret, i.bd, i.mtc0_we, i.cp0_addr, i.ex, i.excode, i.res_from_cp0,
                i.alu, i.gr_we, i.dest, r, i.pc};
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int kind;
        kind = int'($urandom_range(0, 6));
        i = mk(kind, 1'($urandom), 2'($urandom), $urandom, $urandom);
        i.eret = ($urandom_range(0, 15) == 0);
        i.bd = 1'($urandom); i.mtc0_we = 1'($urandom); i.res_from_cp0 = 1'($urandom);
        i.cp0_addr = 5'($urandom); i.excode = 5'($urandom); i.dest = 5'($urandom);
        i.gr_we = 1'($urandom); i.pc = $urandom;
        if (kind == 0) i.ex = ($urandom_range(0, 7) == 0);
        return i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ex_from_ws = 1'b0;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0; ws_allowin = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    vec_t   tbl[17];
    instr_t ins, cur, nxt;
    logic [31:0] cur_d;
    logic occ, got, ld, ready, exp_allow;

    initial begin
        tbl[0]  = '{0, 1'b0, 2'd0, 32'h0,        32'h5555_5555, 32'h0000_1234, 32'h0000_1234};
        tbl[1]  = '{3, 1'b1, 2'd2, 32'h0,        32'h11C0_3344, 32'h0000_1002, 32'hFFFF_FFC0};
        tbl[2]  = '{4, 1'b0, 2'd1, 32'hAABBCCDD, 32'h1122_3344, 32'h0000_1001, 32'h3344_CCDD};
        tbl[3]  = '{3, 1'b0, 2'd2, 32'h0,        32'h11C0_3344, 32'h0000_1002, 32'h0000_00C0};
        tbl[4]  = '{2, 1'b1, 2'd2, 32'h0,        32'h8001_7FFF, 32'h0000_1002, 32'hFFFF_8001};
        tbl[5]  = '{2, 1'b0, 2'd0, 32'h0,        32'h8001_F00F, 32'h0000_1000, 32'h0000_F00F};
        tbl[6]  = '{2, 1'b1, 2'd0, 32'h0,        32'h1234_F00F, 32'h0000_1000, 32'hFFFF_F00F};
        tbl[7]  = '{3, 1'b1, 2'd3, 32'h0,        32'h7F00_0000, 32'h0000_1003, 32'h0000_007F};
        tbl[8]  = '{3, 1'b1, 2'd0, 32'h0,        32'h0000_0080, 32'h0000_1000, 32'hFFFF_FF80};
        tbl[9]  = '{4, 1'b0, 2'd0, 32'hAABBCCDD, 32'h1122_3344, 32'h0000_1000, 32'h44BB_CCDD};
        tbl[10] = '{4, 1'b0, 2'd2, 32'hAABBCCDD, 32'h1122_3344, 32'h0000_1002, 32'h2233_44DD};
        tbl[11] = '{4, 1'b0, 2'd3, 32'hAABBCCDD, 32'h1122_3344, 32'h0000_1003, 32'h1122_3344};
        tbl[12] = '{5, 1'b0, 2'd0, 32'hAABBCCDD, 32'h1122_3344, 32'h0000_1000, 32'h1122_3344};
        tbl[13] = '{5, 1'b0, 2'd1, 32'hAABBCCDD, 32'h1122_3344, 32'h0000_1001, 32'hAA11_2233};
        tbl[14] = '{5, 1'b0, 2'd2, 32'hAABBCCDD, 32'h1122_3344, 32'h0000_1002, 32'hAABB_1122};
        tbl[15] = '{5, 1'b0, 2'd3, 32'hAABBCCDD, 32'h1122_3344, 32'h0000_1003, 32'hAABB_CC11};
        tbl[16] = '{1, 1'b0, 2'd0, 32'h0,        32'hDEAD_BEEF, 32'h0000_1000, 32'hDEAD_BEEF};

        do_reset();
        chk("reset_allowin", 128'(ms_allowin), 128'd1);
        chk("reset_valid",   128'(ms_to_ws_valid), 128'd0);
        chk("reset_bus",     128'(ms_to_ws_bus), 128'd0);
        chk("reset_exms",    128'(ex_from_ms), 128'd0);
        chk("reset_fwd",     128'(ms_forward), 128'd0);
        chk("reset_fwdok",   128'(ms_fwd_ok), 128'd0);
        chk("reset_pend",    128'(ms_load_pending), 128'd0);

        // Alignment table: each instruction gets its response in its first MEM cycle.
        for (int k = 0; k < 17; k++) begin
            ins = mk(tbl[k].kind, tbl[k].sign, tbl[k].off, tbl[k].rt, tbl[k].alu);
            es_to_ms_valid = 1'b1; es_to_ms_bus = pack_es(ins); ws_allowin = 1'b1;
            tick();
            es_to_ms_valid = 1'b0;
            data_sram_data_ok = (tbl[k].kind != 0);
            data_sram_rdata = tbl[k].rdata;
            #1;
            chk($sformatf("tbl%0d_valid", k), 128'(ms_to_ws_valid), 128'd1);
            chk($sformatf("tbl%0d_result", k), 128'(ms_to_ws_bus[63:32]), 128'(tbl[k].exp));
            chk($sformatf("tbl%0d_fwd", k), 128'(ms_forward), 128'(tbl[k].exp));
            chk($sformatf("tbl%0d_allowin", k), 128'(ms_allowin), 128'd1);
            tick();
            data_sram_data_ok = 1'b0;
        end

        // LW completes while WB is stalled: HOLD keeps the data stable.
        ins = mk(1, 1'b0, 2'd0, 32'h0, 32'h0000_2000);
        es_to_ms_valid = 1'b1; es_to_ms_bus = pack_es(ins); ws_allowin = 1'b0;
        tick();
        es_to_ms_valid = 1'b0; #1;
        chk("hold_wait_pend",    128'(ms_load_pending), 128'd1);
        chk("hold_wait_valid",   128'(ms_to_ws_valid), 128'd0);
        chk("hold_wait_allowin", 128'(ms_allowin), 128'd0);
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D; #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("hold%0d_valid", c),   128'(ms_to_ws_valid), 128'd1);
            chk($sformatf("hold%0d_result", c),  128'(ms_to_ws_bus[63:32]), 128'hCAFE_F00D);
            chk($sformatf("hold%0d_allowin", c), 128'(ms_allowin), 128'd0);
            tick();
            data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0BAD_0BAD; #1;
        end
        ws_allowin = 1'b1; #1;
        chk("hold_rel_allowin", 128'(ms_allowin), 128'd1);
        chk("hold_rel_result",  128'(ms_to_ws_bus[63:32]), 128'hCAFE_F00D);
        tick();
        chk("hold_gone_valid", 128'(ms_to_ws_valid), 128'd0);

        // Flush in WAIT: the stale response is discarded, the next load takes the one after.
        es_to_ms_valid = 1'b1; es_to_ms_bus = pack_es(ins);
        tick();
        es_to_ms_valid = 1'b0; ex_from_ws = 1'b1;
        tick();
        ex_from_ws = 1'b0; #1;
        chk("flush_valid",   128'(ms_to_ws_valid), 128'd0);
        chk("flush_allowin", 128'(ms_allowin), 128'd1);
        ins = mk(1, 1'b0, 2'd0, 32'h0, 32'h0000_3000);
        es_to_ms_valid = 1'b1; es_to_ms_bus = pack_es(ins);
        tick();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBAD0_BAD0; #1;
        chk("drop_stale_valid", 128'(ms_to_ws_valid), 128'd0);
        chk("drop_stale_pend",  128'(ms_load_pending), 128'd1);
        tick();
        data_sram_rdata = 32'h600D_600D; #1;
        chk("drop_next_valid",  128'(ms_to_ws_valid), 128'd1);
        chk("drop_next_result", 128'(ms_to_ws_bus[63:32]), 128'h600D_600D);
        tick();
        data_sram_data_ok = 1'b0; #1;
        chk("drop_done_valid", 128'(ms_to_ws_valid), 128'd0);

        // Flush wins over a simultaneous accept.
        ins = mk(0, 1'b0, 2'd0, 32'h0, 32'h0000_4000);
        es_to_ms_valid = 1'b1; es_to_ms_bus = pack_es(ins);
        tick();
        ex_from_ws = 1'b1;
        tick();
        ex_from_ws = 1'b0; es_to_ms_valid = 1'b0; #1;
        chk("flush_accept_valid", 128'(ms_to_ws_valid), 128'd0);

        // Excepting load passes straight through.
        ins = mk(6, 1'b0, 2'd0, 32'h0, 32'h0000_1003);
        ins.excode = 5'h04;
        es_to_ms_valid = 1'b1; es_to_ms_bus = pack_es(ins);
        tick();
        es_to_ms_valid = 1'b0; #1;
        chk("exc_valid",    128'(ms_to_ws_valid), 128'd1);
        chk("exc_exms",     128'(ex_from_ms), 128'd1);
        chk("exc_ex",       128'(ms_to_ws_bus[108]), 128'd1);
        chk("exc_excode",   128'(ms_to_ws_bus[107:103]), 128'h04);
        chk("exc_badvaddr", 128'(ms_to_ws_bus[101:70]), 128'h1003);
        chk("exc_pend",     128'(ms_load_pending), 128'd0);
        tick();

        // Random traffic against a transaction-level model of one MEM slot.
        do_reset();
        occ = 1'b0; got = 1'b0; ld = 1'b0; cur = mk(0, 1'b0, 2'd0, 32'h0, 32'h0); cur_d = '0;
        for (int c = 0; c < 3000; c++) begin
            nxt = rand_instr();
            es_to_ms_valid = ($urandom_range(0, 2) != 0);
            es_to_ms_bus = pack_es(nxt);
            ws_allowin = ($urandom_range(0, 3) != 0);
            data_sram_data_ok = occ & ld & ~got & ($urandom_range(0, 2) == 0);
            data_sram_rdata = data_sram_data_ok ? cur_d : $urandom;
            ready = occ & (~ld | got | data_sram_data_ok);
            exp_allow = ~occ | (ready & ws_allowin);
            #1;
            chk("rnd_allowin", 128'(ms_allowin), 128'(exp_allow));
            chk("rnd_valid",   128'(ms_to_ws_valid), 128'(ready));
            chk("rnd_fwdok",   128'(ms_fwd_ok), 128'(ready & cur.gr_we));
            chk("rnd_pend",    128'(ms_load_pending), 128'(occ & ld & ~ready));
            chk("rnd_exms",    128'(ex_from_ms), 128'(occ & (cur.ex | cur.eret)));
            if (ready) chk("rnd_bus", 128'(ms_to_ws_bus), 128'(exp_bus(cur, cur_d)));
            if (data_sram_data_ok) got = 1'b1;
            if (ready & ws_allowin) occ = 1'b0;
            if (exp_allow & es_to_ms_valid) begin
                occ = 1'b1; cur = nxt; ld = is_wait_load(nxt); got = 1'b0; cur_d = $urandom;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
